sfu_range_reduce: RTL



---
 rtl/sfu_pkg.sv | 64 ++++++
 rtl/sfu_rro_shift.sv | 28 ++
 rtl/sfu_range_reduce.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sfu_pkg.sv
// sfu_pkg: constants, field widths and types shared by the SFU range-reduction stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfu_pkg;

  // SFU opcodes that take the reduced path; every other opcode passes through.
  localparam logic [2:0] SFU_SIN = 3'b000;
  localparam logic [2:0] SFU_COS = 3'b001;
  localparam logic [2:0] SFU_EX2 = 3'b100;

  // 1/(2*pi) as unsigned Q0.32.
  localparam logic [31:0] INV_2PI = 32'h28BE60DB;

  // Pipeline depth of the stage; fixed by construction.
  localparam int RRO_LAT = 3;

  // fp32 field layout.
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  // Reduced-operand layout and datapath widths.
  localparam int RRO_PAY_W  = 30;
  localparam int RRO_PROD_W = FP32_MAN_W + 1 + 32;  // 24x32 product
  localparam int RRO_SH_W   = 10;                   // signed shift amount
  // Product LSB weight is 2^(E-55); a Q0.30 payload needs weight 2^-30,
  // so the trig path shifts left by E-25.
  localparam int RRO_TRIG_SH = 25;
  // ex2 input magnitude overflows Q7.23 once the unbiased exponent reaches 7.
  localparam int RRO_EX2_MAX_E = 7;

  typedef struct packed {
    logic                 sign;
    logic                 special;
    logic [RRO_PAY_W-1:0] payload;
  } rro_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  typedef enum logic [1:0] {
    PATH_PASS,
    PATH_TRIG,
    PATH_EX2
  } rro_path_e;

  // Denormals are flushed, so an all-zero exponent field counts as zero.
  function automatic fp_cls_e fp_classify(input logic [FP32_EXP_W-1:0] exp_f,
                                          input logic [FP32_MAN_W-1:0] man_f);
    fp_cls_e cls;
    cls = CLS_NORM;
    if (exp_f == '0) begin
      cls = CLS_ZERO;
    end else if (exp_f == '1) begin
      cls = (man_f == '0) ? CLS_INF : CLS_NAN;
    end
    return cls;
  endfunction

endpackage

// File: rtl/sfu_rro_shift.sv
// sfu_rro_shift: 56-bit bidirectional barrel shifter with a 30-bit truncated result.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: din_i  - unsigned magnitude to be aligned
//        sh_i   - two's-complement shift amount, positive = left, negative = right
//        dout_o - low 30 bits of the shifted value; zero once |sh_i| >= 56
module sfu_rro_shift
  import sfu_pkg::*;
(
  input  logic [RRO_PROD_W-1:0] din_i,
  input  logic [RRO_SH_W-1:0]   sh_i,
  output logic [RRO_PAY_W-1:0]  dout_o
);

  logic [RRO_SH_W-1:0] amt;

  always_comb begin
    amt = sh_i[RRO_SH_W-1] ? -sh_i : sh_i;
    if (amt >= RRO_SH_W'(RRO_PROD_W)) begin
      dout_o = '0;
    end else if (sh_i[RRO_SH_W-1]) begin
      dout_o = RRO_PAY_W'(din_i >> amt);
    end else begin
      dout_o = RRO_PAY_W'(din_i << amt);
    end
  end

endmodule

// File: rtl/sfu_range_reduce.sv
// sfu_range_reduce: fp32 -> fixed-point range reduction for the sin/cos/ex2 evaluators.
// Latency: 3 cycles accept-to-valid_o, 1 item per cycle.
// Backpressure: single global stall, ready_o = ~valid_o | ready_i; all stages hold when stalled.
// Ports: clk_i/rst_i          - clock, synchronous active-high reset
//        valid_i/ready_o      - input handshake; selop_i opcode, src_i fp32 operand
//        valid_o/ready_i      - output handshake; selop_o/src_o raw opcode and operand,
//                               rro_o reduced operand {sign, special, payload[29:0]}
module sfu_range_reduce
  import sfu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  selop_i,
  input  logic [31:0] src_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [2:0]  selop_o,
  output logic [31:0] src_o,
  output logic [31:0] rro_o
);

  logic adv;

  // S1: unpack, classify, multiply
  logic                  s1_vld_d,   s1_vld_q;
  logic [2:0]            s1_selop_d, s1_selop_q;
  logic [31:0]           s1_src_d,   s1_src_q;
  logic                  s1_sign_d,  s1_sign_q;
  fp_cls_e               s1_cls_d,   s1_cls_q;
  rro_path_e             s1_path_d,  s1_path_q;
  logic                  s1_ovf_d,   s1_ovf_q;
  logic [RRO_PROD_W-1:0] s1_mag_d,   s1_mag_q;
  logic [RRO_SH_W-1:0]   s1_sh_d,    s1_sh_q;

  // S2: shift and payload select
  logic                 s2_vld_d,     s2_vld_q;
  logic [2:0]           s2_selop_d,   s2_selop_q;
  logic [31:0]          s2_src_d,     s2_src_q;
  logic                 s2_sign_d,    s2_sign_q;
  logic                 s2_special_d, s2_special_q;
  logic                 s2_pass_d,    s2_pass_q;
  logic [RRO_PAY_W-1:0] s2_pay_d,     s2_pay_q;

  // S3: packed output register
  logic        out_vld_d,   out_vld_q;
  logic [2:0]  out_selop_d, out_selop_q;
  logic [31:0] out_src_d,   out_src_q;
  logic [31:0] out_rro_d,   out_rro_q;

  logic [FP32_EXP_W-1:0] in_exp;
  logic [FP32_MAN_W:0]   in_man;
  logic [RRO_SH_W-1:0]   in_e;
  logic [RRO_PAY_W-1:0]  sh_pay;
  rro_t                  pack;

  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  always_comb begin
    in_exp = src_i[30:23];
    in_man = {1'b1, src_i[22:0]};
    in_e   = RRO_SH_W'(in_exp) - RRO_SH_W'(FP32_BIAS);

    s1_vld_d   = s1_vld_q;
    s1_selop_d = s1_selop_q;
    s1_src_d   = s1_src_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_path_d  = s1_path_q;
    s1_ovf_d   = s1_ovf_q;
    s1_mag_d   = s1_mag_q;
    s1_sh_d    = s1_sh_q;

    if (adv) begin
      s1_vld_d = valid_i;
      if (valid_i) begin
        s1_selop_d = selop_i;
        s1_src_d   = src_i;
        s1_sign_d  = src_i[31];
        s1_cls_d   = fp_classify(in_exp, src_i[22:0]);
        s1_ovf_d   = (in_exp >= FP32_EXP_W'(FP32_BIAS + RRO_EX2_MAX_E));
        s1_path_d  = PATH_PASS;
        s1_mag_d   = '0;
        s1_sh_d    = '0;
        // Both reduced paths feed the same shifter: trig shifts the
        // product, ex2 shifts the bare mantissa.
        if (selop_i == SFU_SIN || selop_i == SFU_COS) begin
          s1_path_d = PATH_TRIG;
          s1_mag_d  = RRO_PROD_W'(in_man) * RRO_PROD_W'(INV_2PI);
          s1_sh_d   = in_e - RRO_SH_W'(RRO_TRIG_SH);
        end else if (selop_i == SFU_EX2) begin
          s1_path_d = PATH_EX2;
          s1_mag_d  = RRO_PROD_W'(in_man);
          s1_sh_d   = in_e;
        end
      end
    end
  end

  sfu_rro_shift u_shift (
    .din_i  (s1_mag_q),
    .sh_i   (s1_sh_q),
    .dout_o (sh_pay)
  );

  always_comb begin
    s2_vld_d     = s2_vld_q;
    s2_selop_d   = s2_selop_q;
    s2_src_d     = s2_src_q;
    s2_sign_d    = s2_sign_q;
    s2_special_d = s2_special_q;
    s2_pass_d    = s2_pass_q;
    s2_pay_d     = s2_pay_q;

    if (adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_selop_d   = s1_selop_q;
        s2_src_d     = s1_src_q;
        s2_sign_d    = s1_sign_q;
        s2_special_d = 1'b0;
        s2_pass_d    = 1'b0;
        s2_pay_d     = '0;
        case (s1_path_q)
          PATH_TRIG: begin
            case (s1_cls_q)
              CLS_NORM: s2_pay_d = sh_pay;
              CLS_INF, CLS_NAN: begin
                s2_special_d = 1'b1;
                s2_pay_d     = '1;
              end
              default: s2_pay_d = '0;
            endcase
          end
          PATH_EX2: begin
            case (s1_cls_q)
              CLS_NORM: begin
                if (s1_ovf_q) begin
                  s2_special_d = 1'b1;
                end else begin
                  s2_pay_d = sh_pay;
                end
              end
              CLS_INF: s2_special_d = 1'b1;
              CLS_NAN: begin
                s2_special_d = 1'b1;
                s2_pay_d     = '1;
              end
              default: s2_pay_d = '0;
            endcase
          end
          default: s2_pass_d = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    pack.sign    = s2_sign_q;
    pack.special = s2_special_q;
    pack.payload = s2_pay_q;

    out_vld_d   = out_vld_q;
    out_selop_d = out_selop_q;
    out_src_d   = out_src_q;
    out_rro_d   = out_rro_q;

    if (adv) begin
      out_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        out_selop_d = s2_selop_q;
        out_src_d   = s2_src_q;
        out_rro_d   = s2_pass_q ? s2_src_q : pack;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q     <= 1'b0;
      s1_selop_q   <= '0;
      s1_src_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= CLS_ZERO;
      s1_path_q    <= PATH_PASS;
      s1_ovf_q     <= 1'b0;
      s1_mag_q     <= '0;
      s1_sh_q      <= '0;
      s2_vld_q     <= 1'b0;
      s2_selop_q   <= '0;
      s2_src_q     <= '0;
      s2_sign_q    <= 1'b0;
      s2_special_q <= 1'b0;
      s2_pass_q    <= 1'b0;
      s2_pay_q     <= '0;
      out_vld_q    <= 1'b0;
      out_selop_q  <= '0;
      out_src_q    <= '0;
      out_rro_q    <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_selop_q   <= s1_selop_d;
      s1_src_q     <= s1_src_d;
      s1_sign_q    <= s1_sign_d;
      s1_cls_q     <= s1_cls_d;
      s1_path_q    <= s1_path_d;
      s1_ovf_q     <= s1_ovf_d;
      s1_mag_q     <= s1_mag_d;
      s1_sh_q      <= s1_sh_d;
      s2_vld_q     <= s2_vld_d;
      s2_selop_q   <= s2_selop_d;
      s2_src_q     <= s2_src_d;
      s2_sign_q    <= s2_sign_d;
      s2_special_q <= s2_special_d;
      s2_pass_q    <= s2_pass_d;
      s2_pay_q     <= s2_pay_d;
      out_vld_q    <= out_vld_d;
      out_selop_q  <= out_selop_d;
      out_src_q    <= out_src_d;
      out_rro_q    <= out_rro_d;
    end
  end

  assign valid_o = out_vld_q;
  assign selop_o = out_selop_q;
  assign src_o   = out_src_q;
  assign rro_o   = out_rro_q;

endmodule
